seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for NUM_DIGITS hex digits. Features: per-digit decimal points, optional leading-zero blanking, PWM brightness, and tear-free double-buffered data load committed only at frame boundaries. Sits between core/debug logic and board anode/cathode pins. Successor to the fixed 4-digit hex display path.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DIV_COUNT, 50000, clk cycles per PWM phase tick (>=1)
AN_ACTIVE_LOW, 1, 1: anode asserted = 0
CAT_ACTIVE_LOW, 1, 1: segment lit = 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 rightmost
dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
load  in  1  strobe: capture data/dp into pending buffer
blank_lz  in  1  1 = blank leading zero digits
brightness  in  3  duty level 0..7, on-time = (brightness+1)/8
enable  in  1  0 = all anodes inactive
anode  out  NUM_DIGITS  digit select, polarity per AN_ACTIVE_LOW
catode  out  8  {dp,g,f,e,d,c,b,a}, polarity per CAT_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high; applies in any state, including mid-frame.
- Reset values:
  - prescaler, phase and digit index = 0.
  - shadow and pending buffers = 0; pending flag = 0.
  - anode = all inactive; catode = all segments off; frame_tick = 0.
- Prescaler: cnt counts 0..DIV_COUNT-1; tick is asserted when cnt == DIV_COUNT-1, then cnt wraps to 0.
- Phase: 3-bit counter, increments on tick. When phase == 7 and tick, the digit index advances. Index wraps NUM_DIGITS-1 -> 0.
- Timing: slot = 8*DIV_COUNT cycles; frame = NUM_DIGITS*8*DIV_COUNT cycles.
- Frame boundary: the cycle where the index wraps to 0. frame_tick is registered and pulses high the cycle after the boundary.
- Load handshake:
  - load=1 captures data/dp into pending and sets the pending flag. Multiple loads within a frame: the last one wins.
  - At a frame boundary with the flag set: shadow <= pending, flag cleared.
  - load asserted on the boundary cycle itself: data is written to shadow directly on that cycle, flag cleared.
  - Display always reads shadow only; no mid-frame tearing.
- Anode: the selected digit is active iff enable && (phase <= brightness). All other anodes are inactive.
- Leading-zero blanking: digit i (i >= 1) is blanked iff blank_lz && nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never blanked.
- Blanked digit: segments a..g off; dp still follows dp[i].
- Glyphs, active-high, before polarity inversion: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 B=7C C=39 D=5E E=79 F=71 (hex).
- Outputs: anode and catode are registered together, giving one cycle latency from index/phase state. They are never misaligned.
- enable=0: counters keep running and shadow updates continue; anodes inactive; catode is don't-care but driven off.

Decomposition:
- seg7_pkg: glyph constants, hex-to-segment function, segment bit-index constants.
- Sub-module seg7_decode (combinational): inputs nibble, blank, dp; output 8-bit active-high segments.
- Prescaler, phase/index counters, buffers and output registers stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV_COUNT=2 (slot = 16 cycles, frame = 64), both polarity params = 1.
1. Reset held 3 cycles -> anode=4'b1111, catode=8'hFF, frame_tick=0. Shadow shows 0000 after release.
2. load data=16'h12AF, dp=0, brightness=7, enable=1 -> from the first frame boundary after load:
   - anode sequence 1110, 1101, 1011, 0111, each 16 cycles.
   - catode 8'h8E, 8'h88, 8'hA4, 8'hF9.
   - frame_tick pulses every 64 cycles.
3. data=16'h0040, blank_lz=1, dp=4'b1000 -> digits 3 and 2 blank; digit 3 catode=8'h7F (dp lit only), digit 2 catode=8'hFF. Digit 1 catode=8'h99, digit 0 catode=8'hC0.
4. brightness=1 -> per 16-cycle slot, anode active for exactly 4 cycles (phases 0-1) and inactive for 12. brightness=0 gives 2 active cycles.
5. load 16'h1111 mid-frame, then load 16'h2222 before the boundary -> display unchanged until the boundary, then shows 2222. A load at the boundary cycle is displayed from that frame onward.
6. reset asserted mid-slot of digit 2 with pending set -> next cycle anode=1111, index 0, pending discarded. After release, display shows 0000 until a new load.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the multiplexed 7-segment display path.
//               Provides segment bit positions within the 8-bit cathode word
//               ({dp,g,f,e,d,c,b,a}), the sixteen hex glyphs (active-high),
//               and a helper mapping a nibble to its glyph.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Bit positions inside the 8-bit segment word {dp,g,f,e,d,c,b,a}.
    localparam int c_seg_a  = 0;
    localparam int c_seg_g  = 6;
    localparam int c_seg_dp = 7;

    // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] c_glyph_0 = 7'h3F;
    localparam logic [6:0] c_glyph_1 = 7'h06;
    localparam logic [6:0] c_glyph_2 = 7'h5B;
    localparam logic [6:0] c_glyph_3 = 7'h4F;
    localparam logic [6:0] c_glyph_4 = 7'h66;
    localparam logic [6:0] c_glyph_5 = 7'h6D;
    localparam logic [6:0] c_glyph_6 = 7'h7D;
    localparam logic [6:0] c_glyph_7 = 7'h07;
    localparam logic [6:0] c_glyph_8 = 7'h7F;
    localparam logic [6:0] c_glyph_9 = 7'h67;
    localparam logic [6:0] c_glyph_a = 7'h77;
    localparam logic [6:0] c_glyph_b = 7'h7C;
    localparam logic [6:0] c_glyph_c = 7'h39;
    localparam logic [6:0] c_glyph_d = 7'h5E;
    localparam logic [6:0] c_glyph_e = 7'h79;
    localparam logic [6:0] c_glyph_f = 7'h71;

    // Hex nibble to active-high a..g segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = c_glyph_0;
            4'h1:    seg = c_glyph_1;
            4'h2:    seg = c_glyph_2;
            4'h3:    seg = c_glyph_3;
            4'h4:    seg = c_glyph_4;
            4'h5:    seg = c_glyph_5;
            4'h6:    seg = c_glyph_6;
            4'h7:    seg = c_glyph_7;
            4'h8:    seg = c_glyph_8;
            4'h9:    seg = c_glyph_9;
            4'hA:    seg = c_glyph_a;
            4'hB:    seg = c_glyph_b;
            4'hC:    seg = c_glyph_c;
            4'hD:    seg = c_glyph_d;
            4'hE:    seg = c_glyph_e;
            default: seg = c_glyph_f;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational digit decoder. Converts one hex nibble plus a
//               blank request and a decimal-point bit into an active-high
//               8-bit segment word {dp,g,f,e,d,c,b,a}. A blanked digit turns
//               a..g off but still shows its decimal point.
// Ports       : i_nibble [3:0] hex value to show
//               i_blank        1 = force segments a..g off
//               i_dp           1 = decimal point lit
//               o_seg    [7:0] active-high segment word
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = '0;
        if (!i_blank) begin
            o_seg[c_seg_g:c_seg_a] = hex_to_seg(i_nibble);
        end
        o_seg[c_seg_dp] = i_dp;
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed 7-segment driver for NUM_DIGITS hex digits with
//               per-digit decimal points, optional leading-zero blanking,
//               8-step PWM brightness and a double-buffered data load that
//               only reaches the display at frame boundaries.
//
//               Timing: a prescaler ticks every DIV_COUNT clocks, a 3-bit
//               phase counter advances on each tick, and the digit index
//               advances when the phase wraps. One digit slot is therefore
//               8*DIV_COUNT clocks and a frame NUM_DIGITS slots.
//
// Ports       : clk         system clock
//               reset       synchronous active-high reset
//               data        hex nibbles, nibble i = digit i (0 rightmost)
//               dp          decimal point per digit, 1 = lit
//               load        capture data/dp into the pending buffer
//               blank_lz    1 = blank leading zero digits
//               brightness  duty level, on-time = (brightness+1)/8 of a slot
//               enable      0 = all anodes inactive
//               anode       digit select, polarity set by AN_ACTIVE_LOW
//               catode      {dp,g,f,e,d,c,b,a}, polarity set by CAT_ACTIVE_LOW
//               frame_tick  one-cycle pulse after each frame boundary
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_COUNT      = 50000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit CAT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [2:0]              brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              catode,
    output logic                    frame_tick
);

    localparam int c_cnt_w = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(DIV_COUNT - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [2:0]            c_phase_last = 3'd7;

    // "Off" levels for the pins; XOR with these converts an active-high
    // pattern into pin polarity.
    localparam logic [NUM_DIGITS-1:0] c_an_off  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0]            c_cat_off = {8{CAT_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_phase;
    logic [c_idx_w-1:0] r_idx;

    logic w_tick;
    logic w_slot_end;
    logic w_boundary;

    assign w_tick     = (r_cnt == c_cnt_last);
    assign w_slot_end = w_tick && (r_phase == c_phase_last);
    // The cycle on which the index wraps back to digit 0.
    assign w_boundary = w_slot_end && (r_idx == c_idx_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= '0;
            r_idx   <= '0;
        end else begin
            if (w_tick) begin
                r_cnt   <= '0;
                r_phase <= r_phase + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_slot_end) begin
                if (r_idx == c_idx_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: load writes the pending copy; the shadow copy (the
    // only one the display reads) changes only on a frame boundary. A load
    // landing exactly on the boundary goes straight to the shadow so it is
    // not delayed by a whole frame.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_shad_data;
    logic [NUM_DIGITS-1:0]   r_shad_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_shad_data <= '0;
            r_shad_dp   <= '0;
        end else if (w_boundary) begin
            if (load) begin
                r_shad_data <= data;
                r_shad_dp   <= dp;
            end else if (r_pend_flag) begin
                r_shad_data <= r_pend_data;
                r_shad_dp   <= r_pend_dp;
            end
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_pend_data <= data;
            r_pend_dp   <= dp;
            r_pend_flag <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit i (i >= 1) blanks when every nibble
    // from the top digit down to i is zero. Digit 0 always shows.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_blank;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = blank_lz &&
                                 (r_shad_data[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    logic [3:0]            w_nibble;
    logic                  w_dig_blank;
    logic                  w_dig_dp;
    logic [NUM_DIGITS-1:0] w_an_onehot;

    always_comb begin
        w_nibble    = '0;
        w_dig_blank = 1'b0;
        w_dig_dp    = 1'b0;
        w_an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nibble       = r_shad_data[4*i +: 4];
                w_dig_blank    = w_blank[i];
                w_dig_dp       = r_shad_dp[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    logic [7:0] w_seg;

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .i_blank  (w_dig_blank),
        .i_dp     (w_dig_dp),
        .o_seg    (w_seg)
    );

    // PWM: the digit is lit for phases 0..brightness of its slot.
    logic w_on;
    assign w_on = enable && (r_phase <= brightness);

    // ------------------------------------------------------------------
    // Output registers: anode and cathode come from the same state, so
    // they always change together one cycle after the counters.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] r_anode;
    logic [7:0]            r_catode;
    logic                  r_frame_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode      <= c_an_off;
            r_catode     <= c_cat_off;
            r_frame_tick <= 1'b0;
        end else begin
            r_anode      <= w_on   ? (w_an_onehot ^ c_an_off) : c_an_off;
            r_catode     <= enable ? (w_seg ^ c_cat_off)      : c_cat_off;
            r_frame_tick <= w_boundary;
        end
    end

    assign anode      = r_anode;
    assign catode     = r_catode;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (4 digits,
//               DIV_COUNT=2, active-low pins). A reference model tracks the
//               time since reset as a plain count and derives digit/phase/
//               frame position arithmetically; table vectors and directed
//               sequences check fixed glyph values and buffer handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND   = 4;
    localparam int DIV  = 2;
    localparam int SLOT = 8 * DIV;
    localparam int FRM  = ND * SLOT;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   data;
    logic [3:0]    dp;
    logic          load;
    logic          blank_lz;
    logic [2:0]    brightness;
    logic          enable;
    logic [3:0]    anode;
    logic [7:0]    catode;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .DIV_COUNT      (DIV),
        .AN_ACTIVE_LOW  (1'b1),
        .CAT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .enable     (enable),
        .anode      (anode),
        .catode     (catode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    bit          m_valid = 1'b0;
    int          m_t;          // clocks elapsed since the last reset edge
    logic [15:0] m_data, m_pdata;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pflag;
    logic [3:0]  exp_anode;
    logic [7:0]  exp_catode;
    logic        exp_ft;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid    = 1'b1;
                m_t        = 0;
                m_data     = '0;
                m_dp       = '0;
                m_pdata    = '0;
                m_pdp      = '0;
                m_pflag    = 1'b0;
                exp_anode  = 4'hF;
                exp_catode = 8'hFF;
                exp_ft     = 1'b0;
            end else if (m_valid) begin
                int          digit;
                int          phase;
                bit          last_of_frame;
                logic [15:0] upper;
                logic [7:0]  seg;
                digit         = (m_t / SLOT) % ND;
                phase         = (m_t / DIV) % 8;
                last_of_frame = ((m_t % FRM) == FRM - 1);
                upper         = m_data >> (4 * digit);
                seg           = 8'h00;
                if (!(blank_lz && digit >= 1 && upper == 16'h0))
                    seg[6:0] = glyph[upper[3:0]];
                seg[7]     = m_dp[digit];
                exp_catode = enable ? ~seg : 8'hFF;
                exp_anode  = (enable && phase <= int'(brightness)) ? ~(4'b0001 << digit) : 4'hF;
                exp_ft     = last_of_frame;
                if (last_of_frame) begin
                    if (load) begin
                        m_data = data;
                        m_dp   = dp;
                    end else if (m_pflag) begin
                        m_data = m_pdata;
                        m_dp   = m_pdp;
                    end
                    m_pflag = 1'b0;
                end else if (load) begin
                    m_pdata = data;
                    m_pdp   = dp;
                    m_pflag = 1'b1;
                end
                m_t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_anode", {28'h0, anode}, {28'h0, exp_anode});
                chk("model_catode", {24'h0, catode}, {24'h0, exp_catode});
                chk("model_ft", {31'h0, frame_tick}, {31'h0, exp_ft});
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic wait_ft();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRM; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("ft_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        blz;
        logic [31:0] cat;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n_on;
        int gap;
        vecs[0] = '{data: 16'h12AF, dp: 4'b0000, blz: 1'b0, cat: 32'hF9_A4_88_8E};
        vecs[1] = '{data: 16'h0040, dp: 4'b1000, blz: 1'b1, cat: 32'h7F_FF_99_C0};
        vecs[2] = '{data: 16'h0000, dp: 4'b0001, blz: 1'b1, cat: 32'hFF_FF_FF_40};
        vecs[3] = '{data: 16'h8E05, dp: 4'b0101, blz: 1'b1, cat: 32'h80_06_C0_12};

        reset      = 1'b1;
        data       = '0;
        dp         = '0;
        load       = 1'b0;
        blank_lz   = 1'b0;
        brightness = 3'd7;
        enable     = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_anode", {28'h0, anode}, 32'hF);
        chk("rst_catode", {24'h0, catode}, 32'hFF);
        chk("rst_ft", {31'h0, frame_tick}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_anode", {28'h0, anode}, 32'hE);
        chk("post_rst_catode", {24'h0, catode}, 32'hC0);

        // Table vectors: glyphs, blanking, decimal points
        foreach (vecs[v]) begin
            blank_lz = vecs[v].blz;
            do_load(vecs[v].data, vecs[v].dp);
            wait_ft();
            repeat (2) @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (d > 0) repeat (SLOT) @(negedge clk);
                chk($sformatf("vec%0d_anode_d%0d", v, d), {28'h0, anode},
                    {28'h0, ~(4'b0001 << d)});
                chk($sformatf("vec%0d_catode_d%0d", v, d), {24'h0, catode},
                    {24'h0, vecs[v].cat[8*d +: 8]});
            end
        end

        // Frame period
        wait_ft();
        gap = 0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            gap++;
            if (frame_tick) break;
        end
        chk("ft_period", gap, FRM);

        // PWM duty: active cycles over one full frame
        brightness = 3'd1;
        repeat (3) @(negedge clk);
        n_on = 0;
        for (int i = 0; i < FRM; i++) begin
            @(negedge clk);
            if (anode != 4'hF) n_on++;
        end
        chk("duty_b1", n_on, 4 * ND);
        brightness = 3'd0;
        repeat (3) @(negedge clk);
        n_on = 0;
        for (int i = 0; i < FRM; i++) begin
            @(negedge clk);
            if (anode != 4'hF) n_on++;
        end
        chk("duty_b0", n_on, 2 * ND);
        brightness = 3'd7;

        // Two loads in one frame: display holds until the boundary, last wins
        wait_ft();
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (10) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        repeat (3) @(negedge clk);
        chk("hold_old_d1", {24'h0, catode}, 32'hC0);
        wait_ft();
        repeat (2) @(negedge clk);
        chk("last_load_d0", {24'h0, catode}, 32'hA4);

        // Load on the boundary cycle itself
        repeat (FRM - 3) @(negedge clk);
        do_load(16'h3333, 4'b0000);
        chk("bnd_tick", {31'h0, frame_tick}, 32'h1);
        @(negedge clk);
        chk("bnd_load_d0", {24'h0, catode}, 32'hB0);

        // Reset mid-slot of digit 2 with a load pending
        blank_lz = 1'b0;
        wait_ft();
        repeat (40) @(negedge clk);
        data = 16'h5555;
        dp   = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_anode", {28'h0, anode}, 32'hF);
        chk("midrst_catode", {24'h0, catode}, 32'hFF);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_idx0", {28'h0, anode}, 32'hE);
        wait_ft();
        repeat (2 + SLOT) @(negedge clk);
        chk("midrst_drop_d1", {24'h0, catode}, 32'hC0);
        wait_ft();
        repeat (2) @(negedge clk);
        chk("midrst_drop_d0", {24'h0, catode}, 32'hC0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            data = 16'($urandom);
            dp   = 4'($urandom);
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 39) == 0) brightness = 3'($urandom);
            if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        load  = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
